// File: rtl/dla_wbload_if.sv
// Command, GB read and WB write bundle for the weight-buffer load sequencer.
// The master side is the sequencer; the slave side is the op sequencer plus the SRAMs.
interface dla_wbload_if #(
   parameter int ADDR_W = 16,
   parameter int WB_AW  = 9,
   parameter int LEN_W  = 16,
   parameter int DATA_W = 64
);
   logic              cmd_valid;
   logic              cmd_ready;
   logic [1:0]        cmd;
   logic [1:0]        cmd_prec;
   logic [ADDR_W-1:0] cmd_base;
   logic [LEN_W-1:0]  cmd_len;
   logic              gb_rd_valid;
   logic              gb_rd_ready;
   logic [ADDR_W-1:0] gb_rd_addr;
   logic              gb_rdata_valid;
   logic [DATA_W-1:0] gb_rdata;
   logic              wb_wr_en;
   logic [WB_AW-1:0]  wb_wr_addr;
   logic [DATA_W-1:0] wb_wdata;
   logic              done;
   logic              aborted;
   logic              busy;

   modport master (
      input  cmd_valid, cmd, cmd_prec, cmd_base, cmd_len,
      input  gb_rd_ready, gb_rdata_valid, gb_rdata,
      output cmd_ready, gb_rd_valid, gb_rd_addr,
      output wb_wr_en, wb_wr_addr, wb_wdata, done, aborted, busy
   );

   modport slave (
      output cmd_valid, cmd, cmd_prec, cmd_base, cmd_len,
      output gb_rd_ready, gb_rdata_valid, gb_rdata,
      input  cmd_ready, gb_rd_valid, gb_rd_addr,
      input  wb_wr_en, wb_wr_addr, wb_wdata, done, aborted, busy
   );
endinterface

// File: rtl/dla_wbload_ctrl.sv
// Global-buffer to weight-buffer load sequencer: issues GB reads with bounded
// outstanding count and writes returned words into WB at a wrapping pointer.
module dla_wbload_ctrl #(
   parameter int ADDR_W   = 16,
   parameter int WB_AW    = 9,
   parameter int LEN_W    = 16,
   parameter int DATA_W   = 64,
   parameter int MAX_OUTS = 4
) (
   input logic         clk,
   input logic         rst_n,
   dla_wbload_if.master bus
);
   localparam logic [1:0] CMD_NORMAL   = 2'd0;
   localparam logic [1:0] CMD_CONTINUE = 2'd1;
   localparam logic [1:0] CMD_RESET    = 2'd2;
   localparam logic [1:0] CMD_STOP     = 2'd3;
   localparam int OW = $clog2(MAX_OUTS + 1);

   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

   state_e            state;
   logic [ADDR_W-1:0] rd_ptr;
   logic [WB_AW-1:0]  wr_ptr;
   logic [LEN_W:0]    words_left;
   logic [OW-1:0]     outs_cnt;
   logic              abort_flag;

   logic [LEN_W:0]    round_up;
   logic [LEN_W:0]    words;
   logic              rd_hs;
   logic              stop_acc;
   logic              rdata_ok;

   // Weights per word is 1 << prec, so the word count is a rounded-up shift.
   always_comb begin
      round_up = {1'b0, bus.cmd_len} + (((LEN_W+1)'(1)) << bus.cmd_prec) - (LEN_W+1)'(1);
      words    = round_up >> bus.cmd_prec;
   end

   assign bus.gb_rd_valid = (state == ISSUE) && (words_left != '0) && (outs_cnt < OW'(MAX_OUTS));
   assign bus.gb_rd_addr  = rd_ptr;
   assign rd_hs           = bus.gb_rd_valid & bus.gb_rd_ready;
   assign stop_acc        = (state == ISSUE) & bus.cmd_valid & (bus.cmd == CMD_STOP);
   assign bus.cmd_ready   = (state == IDLE) | stop_acc;
   // Data with nothing outstanding is a protocol error, and also covers stale returns after reset.
   assign rdata_ok        = bus.gb_rdata_valid & (outs_cnt != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= IDLE;
         rd_ptr         <= '0;
         wr_ptr         <= '0;
         words_left     <= '0;
         outs_cnt       <= '0;
         abort_flag     <= 1'b0;
         bus.done       <= 1'b0;
         bus.aborted    <= 1'b0;
         bus.busy       <= 1'b0;
         bus.wb_wr_en   <= 1'b0;
         bus.wb_wr_addr <= '0;
         bus.wb_wdata   <= '0;
      end else begin
         bus.done     <= 1'b0;
         bus.aborted  <= 1'b0;
         bus.wb_wr_en <= rdata_ok;
         if (rdata_ok) begin
            bus.wb_wr_addr <= wr_ptr;
            bus.wb_wdata   <= bus.gb_rdata;
            wr_ptr         <= wr_ptr + WB_AW'(1);
         end
         if (rd_hs) begin
            rd_ptr     <= rd_ptr + ADDR_W'(1);
            words_left <= words_left - (LEN_W+1)'(1);
         end
         if (rd_hs && !rdata_ok)      outs_cnt <= outs_cnt + OW'(1);
         else if (!rd_hs && rdata_ok) outs_cnt <= outs_cnt - OW'(1);

         case (state)
            IDLE: begin
               if (bus.cmd_valid) begin
                  bus.busy <= 1'b1;
                  case (bus.cmd)
                     CMD_NORMAL, CMD_CONTINUE: begin
                        if (bus.cmd == CMD_NORMAL) begin
                           rd_ptr <= bus.cmd_base;
                           wr_ptr <= '0;
                        end
                        words_left <= words;
                        if (words == '0) begin
                           state    <= DONE;
                           bus.done <= 1'b1;
                        end else begin
                           state <= ISSUE;
                        end
                     end
                     CMD_RESET: begin
                        rd_ptr   <= '0;
                        wr_ptr   <= '0;
                        state    <= DONE;
                        bus.done <= 1'b1;
                     end
                     default: begin
                        state    <= DONE;
                        bus.done <= 1'b1;
                     end
                  endcase
               end
            end
            ISSUE: begin
               // A handshake in the STOP cycle has already been counted above.
               if (stop_acc) begin
                  words_left <= '0;
                  abort_flag <= 1'b1;
                  state      <= DRAIN;
               end else if (rd_hs && words_left == (LEN_W+1)'(1)) begin
                  state <= DRAIN;
               end
            end
            DRAIN: begin
               if (outs_cnt == '0) begin
                  state       <= DONE;
                  bus.done    <= 1'b1;
                  bus.aborted <= abort_flag;
               end
            end
            default: begin
               state      <= IDLE;
               bus.busy   <= 1'b0;
               abort_flag <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_dla_wbload_ctrl.sv
// Randomized self-checking bench for dla_wbload_ctrl with a GB latency model and
// a pointer-arithmetic reference of expected GB reads and WB writes.
module tb_dla_wbload_ctrl;
   localparam int ADDR_W = 16, WB_AW = 4, LEN_W = 16, DATA_W = 64, MAX_OUTS = 4;
   localparam logic [1:0] NORMAL = 2'd0, CONTINUE = 2'd1, RESETC = 2'd2, STOP = 2'd3;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   dla_wbload_if #(.ADDR_W(ADDR_W), .WB_AW(WB_AW), .LEN_W(LEN_W), .DATA_W(DATA_W)) bus();
   dla_wbload_ctrl #(.ADDR_W(ADDR_W), .WB_AW(WB_AW), .LEN_W(LEN_W), .DATA_W(DATA_W),
                     .MAX_OUTS(MAX_OUTS)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

   int checks = 0, errors = 0;
   int cyc = 0, lat = 3, rdy_pct = 100, hs_limit = -1;
   int issued = 0, returned = 0, max_inflight = 0, over_cnt = 0;
   logic [15:0]      pend_addr[$];
   int               pend_due[$];
   logic [15:0]      rd_q[$];
   logic [WB_AW-1:0] wa_q[$];
   logic [63:0]      wd_q[$];
   int mrd = 0, mwr = 0;

   function automatic logic [63:0] gbdat(input logic [15:0] a);
      return {a, ~a, a ^ 16'hA5A5, a + 16'h1234};
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // GB responder and WB monitor; inputs change on the falling edge only.
   always @(negedge clk) begin
      int  outs_now;
      bit  rdy;
      cyc++;
      if (bus.wb_wr_en) begin
         wa_q.push_back(bus.wb_wr_addr);
         wd_q.push_back(bus.wb_wdata);
      end
      outs_now = issued - returned;
      if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
         bus.gb_rdata_valid = 1'b1;
         bus.gb_rdata       = gbdat(pend_addr.pop_front());
         void'(pend_due.pop_front());
         returned++;
      end else begin
         bus.gb_rdata_valid = 1'b0;
         bus.gb_rdata       = {$urandom, $urandom};
      end
      rdy = (hs_limit != 0) && ($urandom_range(99) < rdy_pct);
      bus.gb_rd_ready = rdy;
      if (rdy && bus.gb_rd_valid) begin
         if (outs_now >= MAX_OUTS) over_cnt++;
         if (outs_now + 1 > max_inflight) max_inflight = outs_now + 1;
         rd_q.push_back(bus.gb_rd_addr);
         pend_addr.push_back(bus.gb_rd_addr);
         pend_due.push_back(cyc + lat);
         issued++;
         if (hs_limit > 0) hs_limit--;
      end
   end

   task automatic send(input logic [1:0] c, input logic [1:0] p, input logic [15:0] base,
                       input logic [15:0] len);
      int t = 0;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd = c; bus.cmd_prec = p; bus.cmd_base = base; bus.cmd_len = len;
      #1;
      while (!bus.cmd_ready && t < 200) begin
         @(negedge clk); #1; t++;
      end
      if (!bus.cmd_ready) chk("cmd_accept_timeout", 0, 1);
      @(posedge clk); #1;
      bus.cmd_valid = 1'b0;
   endtask

   task automatic wait_done(output int t, output bit ab);
      bit ok = 0;
      t = 0;
      while (t < 4000) begin
         @(negedge clk); #2; t++;
         if (bus.done) begin ok = 1; break; end
      end
      if (!ok) chk("done_timeout", 0, 1);
      ab = bus.aborted;
   endtask

   task automatic check_traffic(input string nm, input int n);
      chk({nm, "_nrd"}, rd_q.size(), n);
      chk({nm, "_nwr"}, wa_q.size(), n);
      for (int i = 0; i < n; i++) begin
         if (i < rd_q.size()) chk({nm, "_rdaddr"}, rd_q[i], (mrd + i) & 16'hFFFF);
         if (i < wa_q.size()) begin
            chk({nm, "_wraddr"}, wa_q[i], (mwr + i) % (1 << WB_AW));
            chk({nm, "_wrdata"}, wd_q[i], gbdat(16'((mrd + i) & 16'hFFFF)));
         end
      end
      mrd = (mrd + n) & 16'hFFFF;
      mwr = (mwr + n) % (1 << WB_AW);
   endtask

   task automatic load(input string nm, input logic [1:0] c, input logic [1:0] p,
                       input logic [15:0] base, input logic [15:0] len);
      int n, t;
      bit ab;
      n = (c == NORMAL || c == CONTINUE) ? ((int'(len) + (1 << p) - 1) >> p) : 0;
      if (c == NORMAL) begin mrd = int'(base); mwr = 0; end
      if (c == RESETC) begin mrd = 0; mwr = 0; end
      rd_q.delete(); wa_q.delete(); wd_q.delete();
      send(c, p, base, len);
      wait_done(t, ab);
      chk({nm, "_aborted"}, ab, 0);
      check_traffic(nm, n);
      if (n == 0) chk({nm, "_done_lat"}, t, 1);
      @(negedge clk); #2;
      chk({nm, "_idle_busy"}, bus.busy, 0);
   endtask

   initial begin
      int t, ret0;
      bit ab;
      bus.cmd_valid = 1'b0; bus.cmd = '0; bus.cmd_prec = '0; bus.cmd_base = '0; bus.cmd_len = '0;
      repeat (3) @(negedge clk);
      #2;
      chk("rst_busy", bus.busy, 0);
      chk("rst_done", bus.done, 0);
      chk("rst_aborted", bus.aborted, 0);
      chk("rst_rd_valid", bus.gb_rd_valid, 0);
      chk("rst_wr_en", bus.wb_wr_en, 0);
      chk("rst_wr_addr", bus.wb_wr_addr, 0);
      rst_n = 1'b1;

      load("n8", NORMAL, 2'd1, 16'h0100, 16'd16);
      load("cont1", CONTINUE, 2'd3, 16'h0000, 16'd5);

      lat = 10; max_inflight = 0;
      load("lat10", NORMAL, 2'd0, 16'h0400, 16'd12);
      chk("lat10_max_outs", max_inflight, MAX_OUTS);
      lat = 3;

      // STOP after three handshakes with returns in flight
      mrd = 16'h0200; mwr = 0; lat = 12; hs_limit = 3;
      rd_q.delete(); wa_q.delete(); wd_q.delete();
      ret0 = returned;
      send(NORMAL, 2'd0, 16'h0200, 16'd20);
      t = 0;
      while (returned - ret0 < 2 && t < 200) begin @(negedge clk); #2; t++; end
      chk("stop_rd_before", rd_q.size(), 3);
      send(STOP, 2'd0, 16'h0000, 16'd0);
      hs_limit = -1;
      wait_done(t, ab);
      chk("stop_aborted", ab, 1);
      check_traffic("stop", 3);
      @(negedge clk); #2;
      chk("stop_idle_busy", bus.busy, 0);
      lat = 3;

      load("len0", NORMAL, 2'd0, 16'h0500, 16'd0);
      load("stop_idle", STOP, 2'd0, 16'h0000, 16'd0);
      load("cont_after", CONTINUE, 2'd0, 16'h0000, 16'd3);
      load("rstcmd", RESETC, 2'd0, 16'h0000, 16'd0);
      load("cont_rst", CONTINUE, 2'd2, 16'hBEEF, 16'd9);
      load("wrapA", NORMAL, 2'd0, 16'hFFFE, 16'd14);
      load("wrapB", CONTINUE, 2'd0, 16'h0000, 16'd4);

      // asynchronous reset in the middle of a load
      lat = 10;
      rd_q.delete(); wa_q.delete(); wd_q.delete();
      send(NORMAL, 2'd0, 16'h0300, 16'd10);
      t = 0;
      while (rd_q.size() < 3 && t < 200) begin @(negedge clk); #2; t++; end
      @(negedge clk); #2;
      rst_n = 1'b0;
      rd_q.delete(); wa_q.delete(); wd_q.delete();
      @(negedge clk); #2;
      chk("arst_busy", bus.busy, 0);
      chk("arst_rd_valid", bus.gb_rd_valid, 0);
      chk("arst_wr_en", bus.wb_wr_en, 0);
      rst_n = 1'b1;
      t = 0;
      while (pend_due.size() > 0 && t < 100) begin @(negedge clk); t++; end
      repeat (3) @(negedge clk);
      #2;
      chk("arst_drop_wr", wa_q.size(), 0);
      chk("arst_drop_rd", rd_q.size(), 0);
      mrd = 0; mwr = 0; lat = 3;
      load("cont_arst", CONTINUE, 2'd0, 16'h0000, 16'd2);

      for (int k = 0; k < 25; k++) begin
         int r;
         logic [1:0] c;
         lat = $urandom_range(1, 12);
         rdy_pct = $urandom_range(30, 100);
         r = $urandom_range(0, 9);
         c = (r < 5) ? NORMAL : (r < 9) ? CONTINUE : RESETC;
         load("rnd", c, 2'($urandom_range(0, 3)), 16'($urandom), 16'($urandom_range(0, 40)));
      end
      rdy_pct = 100;
      chk("outs_limit", over_cnt, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
